// File: rtl/demux_estrutural_if.sv
// -----------------------------------------------------------------------------
// demux_estrutural_if
//   Groups the demux data/select/output lines so a driver and the demux can be
//   wired with one handle.
//   Signals:
//     D  data bit to be routed
//     S  2-bit select, S = i routes D to Y[i]
//     Y  4-bit one-hot-or-zero registered outputs
//   Modports:
//     master  drives D/S, observes Y (stimulus side)
//     slave   observes D/S, drives Y (demux side)
// -----------------------------------------------------------------------------
interface demux_estrutural_if;
    logic       D;
    logic [1:0] S;
    logic [3:0] Y;

    modport master (output D, output S, input Y);
    modport slave  (input D, input S, output Y);
endinterface

// File: rtl/demux_estrutural.sv
// -----------------------------------------------------------------------------
// demux_estrutural
//   Registered 1-to-4 demultiplexer built from gate primitives and flip-flops.
//   D is steered to Y[S]; every other line is low. One clock of latency, no
//   combinational path from any input to Y.
//   Ports:
//     D      in   1  data bit to be routed
//     S      in   2  select
//     Y      out  4  one-hot-or-zero outputs, registered
//     clk    in   1  rising-edge clock
//     rst_n  in   1  synchronous active-low reset, clears Y
//   The (D, S, Y, clk, rst_n) port order keeps older positional
//   instantiations of (D, S, Y) valid.
// -----------------------------------------------------------------------------

// Single D flip-flop with synchronous reset folded into the data path:
// while rst_n is low the captured value is forced to 0.
module demux_estrutural_dff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_q;

    always_ff @(posedge clk) begin
        r_q <= i_d & rst_n;
    end

    assign o_q = r_q;
endmodule

module demux_estrutural (
    input  logic       D,
    input  logic [1:0] S,
    output logic [3:0] Y,
    input  logic       clk,
    input  logic       rst_n
);
    logic [1:0] w_s_n_p0;
    logic [3:0] w_sel_p0;
    logic [3:0] w_y_next_p0;

    // ---- decode stage: 2-to-4 one-hot select ----
    not u_not_s0 (w_s_n_p0[0], S[0]);
    not u_not_s1 (w_s_n_p0[1], S[1]);

    and u_and_sel0 (w_sel_p0[0], w_s_n_p0[1], w_s_n_p0[0]);
    and u_and_sel1 (w_sel_p0[1], w_s_n_p0[1], S[0]);
    and u_and_sel2 (w_sel_p0[2], S[1],        w_s_n_p0[0]);
    and u_and_sel3 (w_sel_p0[3], S[1],        S[0]);

    // ---- steer stage and register stage, one lane per output line ----
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        and u_and_steer (w_y_next_p0[gi], D, w_sel_p0[gi]);

        demux_estrutural_dff u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .i_d   (w_y_next_p0[gi]),
            .o_q   (Y[gi])
        );
    end
endmodule

// File: tb/tb_demux_estrutural.sv
// -----------------------------------------------------------------------------
// tb_demux_estrutural
//   Self-checking bench for demux_estrutural: a table of directed vectors
//   followed by hand-written multi-cycle sequences and a random sweep.
// -----------------------------------------------------------------------------
module tb_demux_estrutural;
    logic clk;
    logic rst_n;

    demux_estrutural_if bus ();

    demux_estrutural dut (
        .D     (bus.D),
        .S     (bus.S),
        .Y     (bus.Y),
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic       d;
        logic [1:0] s;
        logic [3:0] exp_y;
        string      name;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then let outputs settle off the edge.
    task automatic step(input logic rn, input logic d, input logic [1:0] s);
        rst_n = rn;
        bus.D = d;
        bus.S = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model(input logic d, input logic [1:0] s);
        logic [3:0] y;
        y = 4'b0000;
        if (d) y[s] = 1'b1;
        return y;
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.D = 1'b0;
        bus.S = 2'b00;
        @(negedge clk);

        vecs.push_back('{1'b0, 1'b1, 2'b10, 4'b0000, "reset"});
        vecs.push_back('{1'b1, 1'b1, 2'b00, 4'b0001, "route_s0"});
        vecs.push_back('{1'b1, 1'b1, 2'b01, 4'b0010, "route_s1"});
        vecs.push_back('{1'b1, 1'b1, 2'b10, 4'b0100, "route_s2"});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 4'b1000, "route_s3"});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 4'b0000, "zero_s0"});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 4'b0000, "zero_s1"});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 4'b0000, "zero_s2"});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 4'b0000, "zero_s3"});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 4'b1000, "route_s3_again"});
        vecs.push_back('{1'b1, 1'b1, 2'b01, 4'b0010, "select_switch"});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 4'b0000, "reset_clears"});

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].d, vecs[i].s);
            chk(vecs[i].name, bus.Y, vecs[i].exp_y);
        end

        // Latency: a mid-cycle select change must not reach Y before the edge.
        step(1'b1, 1'b1, 2'b00);
        chk("lat_start", bus.Y, 4'b0001);
        #2;
        bus.S = 2'b11;
        #1;
        chk("lat_hold_sel", bus.Y, 4'b0001);
        bus.D = 1'b0;
        #1;
        chk("lat_hold_data", bus.Y, 4'b0001);
        bus.D = 1'b1;
        @(posedge clk);
        #1;
        chk("lat_update", bus.Y, 4'b1000);

        // Reset mid-operation and release.
        step(1'b1, 1'b1, 2'b10);
        chk("mid_setup", bus.Y, 4'b0100);
        step(1'b0, 1'b1, 2'b10);
        chk("mid_reset", bus.Y, 4'b0000);
        step(1'b1, 1'b1, 2'b10);
        chk("mid_release", bus.Y, 4'b0100);

        // A reset pulse between edges has no effect.
        #2;
        rst_n = 1'b0;
        #2;
        chk("glitch_during", bus.Y, 4'b0100);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("glitch_after", bus.Y, 4'b0100);

        // Random sweep against the reference model plus the one-hot invariant.
        for (int i = 0; i < 220; i++) begin
            logic       d;
            logic [1:0] s;
            d = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            step(1'b1, d, s);
            chk("rand_route", bus.Y, model(d, s));
            checks++;
            if ($countones(bus.Y) > 1) begin
                failures++;
                $display("FAIL rand_onehot actual=%b expected=popcount<=1", bus.Y);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
